seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DWELL, default 1: clk_1khz cycles each digit stays active (legal 1..255).
REQ-002 Parameter BLANK_GAP, default 0: cycles with all digits off at the start of each slot (legal 0..DWELL-1).
REQ-003 clk_1khz  in  1  sole clock; all state updates on its rising edge.
REQ-004 switch_clr  in  1  reset; synchronous, active-high.
REQ-005 dig1..dig6  in  4 each  BCD digit codes from the controller; 0x0-0x9 numeric, 0xA-0xE dash, 0xF blank.
REQ-006 update_req  in  1  level request to capture dig1..dig6; held high until update_ack.
REQ-007 update_ack  out  1  one-cycle pulse; capture performed.
REQ-008 an  out  6  active-low digit enables, one-hot-low; an[k] drives digit k+1.
REQ-009 seg  out  7  active-high segments {g,f,e,d,c,b,a}.
REQ-010 frame_start  out  1  one-cycle pulse when digit 1's slot begins.

Function
REQ-011 Six 4-bit shadow registers SHALL hold the displayed codes; dig1..dig6 SHALL affect outputs only through the shadows.
REQ-012 The scan SHALL use slot index idx (0..5) and dwell counter cnt (0..DWELL-1); cnt increments each cycle; at cnt==DWELL-1, cnt becomes 0 and idx advances, wrapping 5->0.
REQ-013 an, seg, update_ack and frame_start SHALL be registered, reflecting idx/cnt/shadow of the same edge that updates those registers.
REQ-014 When cnt<BLANK_GAP, an SHALL be 6'b111111 and seg 7'b0000000; otherwise an[idx]=0, other bits 1, and seg=decode(shadow[idx]).
REQ-015 Decode: 0->0111111, 1->0000110, 2->1011011, 3->1001111, 4->1100110, 5->1101101, 6->1111101, 7->0000111, 8->1111111, 9->1101111, 0xA-0xE->1000000, 0xF->0000000.
REQ-016 A blank code SHALL still assert its an bit; only seg is zero.
REQ-017 frame_start SHALL be 1 on exactly the cycle where idx==0 and cnt==0, else 0.
REQ-018 If update_req is 1 on an edge that starts a frame (idx becomes 0, cnt becomes 0), all six shadows SHALL load dig1..dig6 on that edge and update_ack SHALL be 1 for that one cycle.
REQ-019 On a capture edge, digit 1's seg SHALL use the newly sampled dig1 value (bypass), never the old shadow; the frame is never torn.
REQ-020 update_req asserted mid-frame SHALL not take effect until the next frame start; digits of the current frame keep old values.
REQ-021 update_req held high continuously SHALL capture and ack every frame.
REQ-022 Frame period SHALL be exactly 6*DWELL cycles; no idle cycles between frames.

Reset
REQ-023 While switch_clr is 1 at an edge: idx=0, cnt=0, all shadows=0xF, an=6'b111111, seg=0, update_ack=0, frame_start=0; reset overrides update_req.
REQ-024 The first edge with switch_clr=0 SHALL start frame 0 (frame_start=1, an=6'b111110 when BLANK_GAP=0) and SHALL honour update_req per REQ-018.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; no ack is issued for a pending request.

Structure
REQ-026 Package seg_pkg SHALL hold NDIG=6, BLANK_CODE=4'hF, the segment pattern constants and the decode table.
REQ-027 Decode SHALL be a combinational sub-module seg_decoder (4-bit code in, 7-bit seg out); scan, shadows and handshake stay in seg_scan_driver.

Verification
REQ-028 Reset: hold switch_clr 3 cycles -> an=111111, seg=0000000, update_ack=0; release with no request -> 6 cycles of an 111110..011111, seg=0 on every digit.
REQ-029 Decode sweep: for codes 0x0..0xF, capture each as dig1 and check seg per REQ-015, incl. 0xC->1000000 and 0xF->0000000 with an=111110.
REQ-030 Scan timing, DWELL=3, BLANK_GAP=1: each slot is 1 cycle all-off then 2 cycles active; frame_start every 18 cycles.
REQ-031 Handshake: dig=1,2,3,4,5,6, update_req raised while idx=2 -> digits 3..6 show the old values, capture on next frame start, update_ack one cycle coincident with frame_start, digit 1 seg=0000110 on that edge.
REQ-032 Reset mid-frame at idx=4 with update_req high -> no ack, shadows return to 0xF, the scan restarts at digit 1 on release, and capture happens on that first edge.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and BCD-to-segment table for the digit scanner
package seg_pkg;

    localparam int NDIG = 6;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Entry [code] is the pattern for that code; 0xA-0xE show a dash, 0xF is blank
    localparam logic [15:0][6:0] DECODE_TABLE = {
        SEG_OFF,  SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        SEG_9,    SEG_8,    SEG_7,    SEG_6,    SEG_5,
        SEG_4,    SEG_3,    SEG_2,    SEG_1,    SEG_0
    };

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational 4-bit code to 7-segment pattern decoder
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = DECODE_TABLE[code];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit multiplexed display scanner with frame-aligned capture
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DWELL     = 1,
    parameter int BLANK_GAP = 0
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dig4,
    input  logic [3:0] dig5,
    input  logic [3:0] dig6,
    input  logic       update_req,
    output logic       update_ack,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam logic [7:0] CNT_MAX  = 8'(DWELL - 1);
    localparam logic [8:0] GAP      = 9'(BLANK_GAP);
    localparam logic [2:0] IDX_LAST = 3'(NDIG - 1);

    logic                  running;
    logic [2:0]            idx;
    logic [2:0]            nxt_idx;
    logic [7:0]            cnt;
    logic [7:0]            nxt_cnt;
    logic [NDIG-1:0][3:0]  shadow;
    logic [NDIG-1:0][3:0]  nxt_shadow;
    logic [NDIG-1:0][3:0]  dig_bus;
    logic                  starts;
    logic                  capture;
    logic                  blank;
    logic [3:0]            code;
    logic [6:0]            dec_seg;

    assign dig_bus = {dig6, dig5, dig4, dig3, dig2, dig1};

    // Outputs are registered from the next-state values so they match the
    // idx/cnt/shadow written on the same edge; the first edge out of reset
    // holds idx/cnt at zero so that edge begins frame 0.
    always_comb begin
        nxt_idx = 3'd0;
        nxt_cnt = 8'd0;
        if (running) begin
            if (cnt == CNT_MAX) begin
                nxt_cnt = 8'd0;
                nxt_idx = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                nxt_cnt = cnt + 8'd1;
                nxt_idx = idx;
            end
        end
        starts     = (nxt_idx == 3'd0) && (nxt_cnt == 8'd0);
        capture    = starts && update_req;
        nxt_shadow = capture ? dig_bus : shadow;
        code       = nxt_shadow[nxt_idx];
        blank      = ({1'b0, nxt_cnt} + 9'd1) <= GAP;
    end

    seg_decoder u_decoder (
        .code (code),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            running     <= 1'b0;
            idx         <= 3'd0;
            cnt         <= 8'd0;
            shadow      <= {NDIG{BLANK_CODE}};
            an          <= 6'b111111;
            seg         <= SEG_OFF;
            update_ack  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= 1'b1;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            shadow      <= nxt_shadow;
            update_ack  <= capture;
            frame_start <= starts;
            an          <= blank ? 6'b111111 : ~(6'b000001 << nxt_idx);
            seg         <= blank ? SEG_OFF : dec_seg;
        end
    end

endmodule
